// File: rtl/kamikaze_ahb_arbiter.sv
// Two-master AHB-Lite arbiter: instruction fetch (I) and load/store (D) share one downstream port.
// Each master has a one-entry address slot so a losing request never stalls the winner.
module kamikaze_ahb_arbiter #(
  parameter int unsigned I_STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] i_haddr_i,
  input  logic [1:0]  i_htrans_i,
  output logic [31:0] i_hrdata_o,
  output logic        i_hready_o,
  output logic        i_hresp_o,
  input  logic [31:0] d_haddr_i,
  input  logic [1:0]  d_htrans_i,
  input  logic        d_hwrite_i,
  input  logic [2:0]  d_hsize_i,
  input  logic [31:0] d_hwdata_i,
  output logic [31:0] d_hrdata_o,
  output logic        d_hready_o,
  output logic        d_hresp_o,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [3:0]  HPROT,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {PH_FREE, PH_PEND, PH_ISSUED} phase_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  localparam logic [3:0] STARVE_MAX = 4'(I_STARVE_MAX);

  phase_e      i_phase_q, i_phase_d, d_phase_q, d_phase_d;
  owner_e      owner_q, owner_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] i_slot_addr_q, i_slot_addr_d;
  logic [31:0] d_slot_addr_q, d_slot_addr_d;
  logic        d_slot_write_q, d_slot_write_d;
  logic [2:0]  d_slot_size_q, d_slot_size_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [3:0]  hprot_q, hprot_d;

  logic        i_accept, d_accept, i_cand, d_cand;
  logic        addr_phase, win_i, win_d;
  logic [31:0] i_sel_addr, d_sel_addr;
  logic        d_sel_write;
  logic [2:0]  d_sel_size;
  logic        unused_htrans_lsb;

  // Only bit1 of HTRANS matters here; NONSEQ and SEQ are treated alike.
  assign unused_htrans_lsb = i_htrans_i[0] ^ d_htrans_i[0];

  assign i_hready_o = rst_i || (i_phase_q == PH_FREE) || ((i_phase_q == PH_ISSUED) && HREADY);
  assign d_hready_o = rst_i || (d_phase_q == PH_FREE) || ((d_phase_q == PH_ISSUED) && HREADY);

  assign i_accept = !rst_i && i_hready_o && i_htrans_i[1];
  assign d_accept = !rst_i && d_hready_o && d_htrans_i[1];
  assign i_cand   = (i_phase_q == PH_PEND) || i_accept;
  assign d_cand   = (d_phase_q == PH_PEND) || d_accept;

  assign addr_phase = HREADY && !rst_i;
  assign win_d = addr_phase && d_cand && !(i_cand && (starve_q == STARVE_MAX));
  assign win_i = addr_phase && i_cand && !win_d;

  assign i_sel_addr  = (i_phase_q == PH_PEND) ? i_slot_addr_q  : i_haddr_i;
  assign d_sel_addr  = (d_phase_q == PH_PEND) ? d_slot_addr_q  : d_haddr_i;
  assign d_sel_write = (d_phase_q == PH_PEND) ? d_slot_write_q : d_hwrite_i;
  assign d_sel_size  = (d_phase_q == PH_PEND) ? d_slot_size_q  : d_hsize_i;

  assign HTRANS    = (win_i || win_d) ? 2'b10 : 2'b00;
  assign HADDR     = haddr_d;
  assign HWRITE    = hwrite_d;
  assign HSIZE     = hsize_d;
  assign HPROT     = hprot_d;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = (owner_q == OWN_D) ? d_hwdata_i : 32'h0;

  assign i_hrdata_o = HRDATA;
  assign d_hrdata_o = HRDATA;
  assign i_hresp_o  = !rst_i && (owner_q == OWN_I) && HRESP;
  assign d_hresp_o  = !rst_i && (owner_q == OWN_D) && HRESP;

  always_comb begin
    i_phase_d      = i_phase_q;
    d_phase_d      = d_phase_q;
    owner_d        = owner_q;
    starve_d       = starve_q;
    i_slot_addr_d  = i_slot_addr_q;
    d_slot_addr_d  = d_slot_addr_q;
    d_slot_write_d = d_slot_write_q;
    d_slot_size_d  = d_slot_size_q;
    haddr_d        = haddr_q;
    hwrite_d       = hwrite_q;
    hsize_d        = hsize_q;
    hprot_d        = hprot_q;

    if (win_i) begin
      i_phase_d = PH_ISSUED;
    end else if (i_accept) begin
      i_phase_d     = PH_PEND;
      i_slot_addr_d = i_haddr_i;
    end else if ((i_phase_q == PH_ISSUED) && HREADY) begin
      i_phase_d = PH_FREE;
    end

    if (win_d) begin
      d_phase_d = PH_ISSUED;
    end else if (d_accept) begin
      d_phase_d      = PH_PEND;
      d_slot_addr_d  = d_haddr_i;
      d_slot_write_d = d_hwrite_i;
      d_slot_size_d  = d_hsize_i;
    end else if ((d_phase_q == PH_ISSUED) && HREADY) begin
      d_phase_d = PH_FREE;
    end

    if (HREADY) begin
      if (win_d)      owner_d = OWN_D;
      else if (win_i) owner_d = OWN_I;
      else            owner_d = OWN_NONE;
    end

    // Count D wins only while I is waiting; the count saturates so I wins next.
    if (!i_cand || win_i) begin
      starve_d = 4'd0;
    end else if (win_d && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end

    if (win_d) begin
      haddr_d  = d_sel_addr;
      hwrite_d = d_sel_write;
      hsize_d  = d_sel_size;
      hprot_d  = 4'b0001;
    end else if (win_i) begin
      haddr_d  = i_sel_addr;
      hwrite_d = 1'b0;
      hsize_d  = 3'b010;
      hprot_d  = 4'b0000;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_phase_q      <= PH_FREE;
      d_phase_q      <= PH_FREE;
      owner_q        <= OWN_NONE;
      starve_q       <= 4'd0;
      i_slot_addr_q  <= 32'h0;
      d_slot_addr_q  <= 32'h0;
      d_slot_write_q <= 1'b0;
      d_slot_size_q  <= 3'b000;
      haddr_q        <= 32'h0;
      hwrite_q       <= 1'b0;
      hsize_q        <= 3'b000;
      hprot_q        <= 4'b0000;
    end else begin
      i_phase_q      <= i_phase_d;
      d_phase_q      <= d_phase_d;
      owner_q        <= owner_d;
      starve_q       <= starve_d;
      i_slot_addr_q  <= i_slot_addr_d;
      d_slot_addr_q  <= d_slot_addr_d;
      d_slot_write_q <= d_slot_write_d;
      d_slot_size_q  <= d_slot_size_d;
      haddr_q        <= haddr_d;
      hwrite_q       <= hwrite_d;
      hsize_q        <= hsize_d;
      hprot_q        <= hprot_d;
    end
  end

endmodule

// File: tb/tb_kamikaze_ahb_arbiter.sv
// Cycle-by-cycle vector table with a scoreboard queue, plus a starvation sequence.
module tb_kamikaze_ahb_arbiter;

  localparam int unsigned STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] i_haddr_i, d_haddr_i, d_hwdata_i, HRDATA;
  logic [1:0]  i_htrans_i, d_htrans_i;
  logic        d_hwrite_i, HREADY, HRESP;
  logic [2:0]  d_hsize_i;
  logic [31:0] i_hrdata_o, d_hrdata_o, HADDR, HWDATA;
  logic        i_hready_o, i_hresp_o, d_hready_o, d_hresp_o, HWRITE, HMASTLOCK;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  kamikaze_ahb_arbiter #(.I_STARVE_MAX(STARVE)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_haddr_i(i_haddr_i), .i_htrans_i(i_htrans_i), .i_hrdata_o(i_hrdata_o),
    .i_hready_o(i_hready_o), .i_hresp_o(i_hresp_o),
    .d_haddr_i(d_haddr_i), .d_htrans_i(d_htrans_i), .d_hwrite_i(d_hwrite_i),
    .d_hsize_i(d_hsize_i), .d_hwdata_i(d_hwdata_i), .d_hrdata_o(d_hrdata_o),
    .d_hready_o(d_hready_o), .d_hresp_o(d_hresp_o),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT),
    .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  itr;
    logic [31:0] iaddr;
    logic [1:0]  dtr;
    logic [31:0] daddr;
    logic        dwr;
    logic [2:0]  dsz;
    logic [31:0] dwd;
    logic        hr;
    logic        hresp;
    logic [31:0] hrd;
  } in_t;

  typedef struct {
    logic        full;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        irdy, drdy, iresp, dresp;
    logic [31:0] rdata;
  } exp_t;

  typedef struct { string name; in_t in; exp_t ex; } vec_t;
  typedef struct { string name; exp_t ex; } sb_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  sb_t  sb_q[$];
  vec_t vecs[$];

  function automatic in_t mk_in(input logic rst, input logic [1:0] itr, input logic [31:0] iaddr,
                                input logic [1:0] dtr, input logic [31:0] daddr, input logic dwr,
                                input logic [2:0] dsz, input logic [31:0] dwd, input logic hr,
                                input logic hresp, input logic [31:0] hrd);
    in_t v;
    v.rst = rst; v.itr = itr; v.iaddr = iaddr; v.dtr = dtr; v.daddr = daddr; v.dwr = dwr;
    v.dsz = dsz; v.dwd = dwd; v.hr = hr; v.hresp = hresp; v.hrd = hrd;
    return v;
  endfunction

  function automatic exp_t mk_ex(input logic [1:0] htrans, input logic [31:0] haddr, input logic hwrite,
                                 input logic [2:0] hsize, input logic [3:0] hprot, input logic [31:0] hwdata,
                                 input logic irdy, input logic drdy, input logic iresp, input logic dresp,
                                 input logic [31:0] rdata);
    exp_t e;
    e.full = 1'b1; e.htrans = htrans; e.haddr = haddr; e.hwrite = hwrite; e.hsize = hsize;
    e.hprot = hprot; e.hwdata = hwdata; e.irdy = irdy; e.drdy = drdy; e.iresp = iresp;
    e.dresp = dresp; e.rdata = rdata;
    return e;
  endfunction

  task automatic add(input string nm, input in_t i, input exp_t e);
    vec_t v;
    v.name = nm; v.in = i; v.ex = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic apply(input string nm, input in_t v, input exp_t e);
    sb_t s;
    @(posedge clk);
    #1;
    rst_i = v.rst; i_htrans_i = v.itr; i_haddr_i = v.iaddr;
    d_htrans_i = v.dtr; d_haddr_i = v.daddr; d_hwrite_i = v.dwr; d_hsize_i = v.dsz;
    d_hwdata_i = v.dwd; HREADY = v.hr; HRESP = v.hresp; HRDATA = v.hrd;
    s.name = nm; s.ex = e;
    sb_q.push_back(s);
  endtask

  sb_t cur;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      chk({cur.name, ".HTRANS"}, 32'(HTRANS), 32'(cur.ex.htrans));
      chk({cur.name, ".HADDR"},  HADDR,         cur.ex.haddr);
      chk({cur.name, ".HPROT"},  32'(HPROT),  32'(cur.ex.hprot));
      if (cur.ex.full) begin
        chk({cur.name, ".HWRITE"},     32'(HWRITE),     32'(cur.ex.hwrite));
        chk({cur.name, ".HSIZE"},      32'(HSIZE),      32'(cur.ex.hsize));
        chk({cur.name, ".HWDATA"},     HWDATA,            cur.ex.hwdata);
        chk({cur.name, ".i_hready_o"}, 32'(i_hready_o), 32'(cur.ex.irdy));
        chk({cur.name, ".d_hready_o"}, 32'(d_hready_o), 32'(cur.ex.drdy));
        chk({cur.name, ".i_hresp_o"},  32'(i_hresp_o),  32'(cur.ex.iresp));
        chk({cur.name, ".d_hresp_o"},  32'(d_hresp_o),  32'(cur.ex.dresp));
        chk({cur.name, ".i_hrdata_o"}, i_hrdata_o,        cur.ex.rdata);
        chk({cur.name, ".d_hrdata_o"}, d_hrdata_o,        cur.ex.rdata);
        chk({cur.name, ".HBURST"},     32'(HBURST),     32'(0));
        chk({cur.name, ".HMASTLOCK"},  32'(HMASTLOCK),  32'(0));
      end
    end
  end

  initial begin
    rst_i = 1'b1; i_htrans_i = 2'b00; i_haddr_i = '0; d_htrans_i = 2'b00; d_haddr_i = '0;
    d_hwrite_i = 1'b0; d_hsize_i = 3'b000; d_hwdata_i = '0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;

    //                 rst itr  iaddr      dtr  daddr     dwr dsz  dwd           hr hresp hrd
    add("reset_gate",   mk_in(1, 2, 32'h999, 0, 32'h0,    0, 0, 32'h0,        1, 0, 32'h0),
                        mk_ex(0, 32'h0,    0, 0, 0, 32'h0,  1, 1, 0, 0, 32'h0));
    add("i_only_addr",  mk_in(0, 2, 32'h100, 0, 32'h0,    0, 0, 32'h0,        1, 0, 32'h0),
                        mk_ex(2, 32'h100,  0, 2, 0, 32'h0,  1, 1, 0, 0, 32'h0));
    add("i_only_data",  mk_in(0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h0,        1, 0, 32'hDEADBEEF),
                        mk_ex(0, 32'h100,  0, 2, 0, 32'h0,  1, 1, 0, 0, 32'hDEADBEEF));
    add("cont_d_wins",  mk_in(0, 2, 32'h200, 2, 32'h8000, 1, 1, 32'hAA,       1, 0, 32'h0),
                        mk_ex(2, 32'h8000, 1, 1, 1, 32'h0,  1, 1, 0, 0, 32'h0));
    add("cont_i_slot",  mk_in(0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h55,       1, 0, 32'h0),
                        mk_ex(2, 32'h200,  0, 2, 0, 32'h55, 0, 1, 0, 0, 32'h0));
    add("cont_i_data",  mk_in(0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h0,        1, 0, 32'h12345678),
                        mk_ex(0, 32'h200,  0, 2, 0, 32'h0,  1, 1, 0, 0, 32'h12345678));
    add("wait_d_addr",  mk_in(0, 2, 32'h300, 2, 32'h4000, 0, 2, 32'h0,        1, 0, 32'h0),
                        mk_ex(2, 32'h4000, 0, 2, 1, 32'h0,  1, 1, 0, 0, 32'h0));
    for (int k = 0; k < 3; k++)
      add($sformatf("wait_%0d", k),
                        mk_in(0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h11,       0, 0, 32'h0),
                        mk_ex(0, 32'h4000, 0, 2, 1, 32'h11, 0, 0, 0, 0, 32'h0));
    add("wait_release", mk_in(0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h11,       1, 0, 32'hCAFEF00D),
                        mk_ex(2, 32'h300,  0, 2, 0, 32'h11, 0, 1, 0, 0, 32'hCAFEF00D));
    add("wait_i_data",  mk_in(0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h11,       1, 0, 32'hA5A5A5A5),
                        mk_ex(0, 32'h300,  0, 2, 0, 32'h0,  1, 1, 0, 0, 32'hA5A5A5A5));
    add("err_addr",     mk_in(0, 0, 32'h0,   2, 32'h5000, 1, 2, 32'h0,        1, 0, 32'h0),
                        mk_ex(2, 32'h5000, 1, 2, 1, 32'h0,  1, 1, 0, 0, 32'h0));
    add("err_cycle1",   mk_in(0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h66,       0, 1, 32'h0),
                        mk_ex(0, 32'h5000, 1, 2, 1, 32'h66, 1, 0, 0, 1, 32'h0));
    add("err_cycle2",   mk_in(0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h66,       1, 1, 32'h0),
                        mk_ex(0, 32'h5000, 1, 2, 1, 32'h66, 1, 1, 0, 1, 32'h0));
    add("err_released", mk_in(0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h66,       1, 1, 32'h0),
                        mk_ex(0, 32'h5000, 1, 2, 1, 32'h0,  1, 1, 0, 0, 32'h0));
    add("rst_setup",    mk_in(0, 2, 32'h600, 2, 32'h7000, 0, 2, 32'h0,        1, 0, 32'h0),
                        mk_ex(2, 32'h7000, 0, 2, 1, 32'h0,  1, 1, 0, 0, 32'h0));
    add("rst_mid",      mk_in(1, 0, 32'h0,   0, 32'h0,    0, 0, 32'h0,        0, 0, 32'h0),
                        mk_ex(0, 32'h7000, 0, 2, 1, 32'h0,  1, 1, 0, 0, 32'h0));
    add("rst_after",    mk_in(0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h99,       1, 0, 32'h0),
                        mk_ex(0, 32'h0,    0, 0, 0, 32'h0,  1, 1, 0, 0, 32'h0));

    repeat (2) @(posedge clk);
    foreach (vecs[n]) apply(vecs[n].name, vecs[n].in, vecs[n].ex);

    // Both masters request every cycle: expect STARVE D grants, then one I grant, repeating.
    begin
      int unsigned s;
      exp_t        e;
      s = 0;
      for (int k = 0; k < 2 * (STARVE + 1); k++) begin
        e = mk_ex(2, 32'h2000, 0, 2, 1, 32'h0, 0, 0, 0, 0, 32'h0);
        e.full = 1'b0;
        if (s == STARVE) begin
          e.haddr = 32'h1000;
          e.hprot = 4'b0000;
          s = 0;
        end else begin
          s++;
        end
        apply($sformatf("starve_%0d", k),
              mk_in(0, 2, 32'h1000, 2, 32'h2000, 0, 2, 32'h0, 1, 0, 32'h0), e);
      end
    end

    @(posedge clk);
    #1;
    i_htrans_i = 2'b00; d_htrans_i = 2'b00;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
